sprint_ram_wb_bridge: RTL and testbench

- Bridges the SprintRV core's native RAM port (ram_ce/sel/addr/we/data, ram_data_rvalid) to the Wishbone-classic data-memory bus (data_mem_*) that the processorci_top data path and Controller consume.
- Queues core requests in a small FIFO and runs one Wishbone transaction at a time, holding cyc/stb until ack.
- Returns read data to the core with a one-cycle rvalid pulse.
- Sits between core_top's RAM interface and the data_mem_* bus.

---
 rtl/sprint_ram_wb_bridge.sv | 190 +++++++++++++++++++
 tb/tb_sprint_ram_wb_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprint_ram_wb_bridge.sv
// sprint_ram_wb_bridge: SprintRV native RAM port -> Wishbone-classic data bus.
// Core requests are queued in a small FIFO and issued one Wishbone transaction
// at a time; read data returns to the core as a one-cycle rvalid pulse.
// Optional macro WB_TIMEOUT_EN adds an ack-wait timeout that aborts the
// transaction, pulses bus_err_o and returns ERR_DATA for reads.
module sprint_ram_wb_bridge #(
    parameter int unsigned REQ_DEPTH      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_data_i,
    output logic        ram_busy_o,
    output logic [31:0] ram_data_o,
    output logic        ram_data_rvalid_o,
    output logic        data_mem_cyc_o,
    output logic        data_mem_stb_o,
    output logic        data_mem_we_o,
    output logic [3:0]  data_mem_sel_o,
    output logic [31:0] data_mem_addr_o,
    output logic [31:0] data_mem_data_o,
    input  logic [31:0] data_mem_data_i,
    input  logic        data_mem_ack_i,
    output logic        bus_err_o
);

    localparam int unsigned PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(REQ_DEPTH);

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [29:0] addr;
        logic [31:0] data;
    } req_t;

    typedef enum logic { S_IDLE, S_BUS } state_t;

    req_t          fifo_q [REQ_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;

    state_t        state_q, state_d;
    req_t          bus_q, bus_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    req_t          in_req, head;
    logic          push, pop, bypass, fifo_wr, expire;
    logic          unused_ok;

    assign in_req  = '{we: ram_we_i, sel: ram_sel_i, addr: ram_addr_i[31:2], data: ram_data_i};
    assign head    = fifo_q[rd_ptr_q];
    assign ram_busy_o = (count_q == FULL);
    assign push    = ram_ce_i && !ram_busy_o;
    // A request that goes straight onto the bus never occupies a FIFO slot.
    assign fifo_wr = push && !bypass;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;

    // Ack in the expiry cycle wins, so expiry requires no ack.
    assign expire    = (state_q == S_BUS) && !data_mem_ack_i && (tmo_q == TMO_LAST);
    assign bus_err_o = err_q;
    assign unused_ok = ^ram_addr_i[1:0];

    // Count BUS cycles without ack; zero whenever a transaction ends or none is open.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= expire;
            if (state_q == S_BUS && !data_mem_ack_i && !expire)
                tmo_q <= tmo_q + 1'b1;
            else
                tmo_q <= '0;
        end
    end
`else
    assign expire    = 1'b0;
    assign bus_err_o = 1'b0;
    assign unused_ok = ^{ram_addr_i[1:0], (TIMEOUT_CYCLES != 0)};
`endif

    // FIFO storage; contents need no reset since count_q gates validity.
    always_ff @(posedge clk_core) begin
        if (fifo_wr)
            fifo_q[wr_ptr_q] <= in_req;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (fifo_wr && !pop)
                count_q <= count_q + 1'b1;
            else if (!fifo_wr && pop)
                count_q <= count_q - 1'b1;
        end
    end

    // FSM state and bus/response registers.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q  <= S_IDLE;
            bus_q    <= '0;
            cyc_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            cyc_q    <= cyc_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next state: issue from FIFO (or directly from the core when empty), complete on ack/expiry.
    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        cyc_d    = cyc_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        pop      = 1'b0;
        bypass   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    bus_d   = head;
                    cyc_d   = 1'b1;
                    state_d = S_BUS;
                end else if (push) begin
                    bypass  = 1'b1;
                    bus_d   = in_req;
                    cyc_d   = 1'b1;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (data_mem_ack_i || expire) begin
                    if (!bus_q.we) begin
                        rvalid_d = 1'b1;
                        rdata_d  = data_mem_ack_i ? data_mem_data_i : ERR_DATA;
                    end
                    // An aborted cycle always drops cyc so the slave sees it end.
                    if (data_mem_ack_i && count_q != '0) begin
                        pop   = 1'b1;
                        bus_d = head;
                    end else begin
                        cyc_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_mem_cyc_o    = cyc_q;
    assign data_mem_stb_o    = cyc_q;
    assign data_mem_we_o     = bus_q.we;
    assign data_mem_sel_o    = bus_q.sel;
    assign data_mem_addr_o   = {bus_q.addr, 2'b00};
    assign data_mem_data_o   = bus_q.data;
    assign ram_data_o        = rdata_q;
    assign ram_data_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_sprint_ram_wb_bridge.sv
// Bench for sprint_ram_wb_bridge: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-level model.
module tb_sprint_ram_wb_bridge;

    localparam int DEPTH = 2;
    localparam int TMO   = 8;
`ifdef WB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk_core = 1'b0;
    logic        rst_core = 1'b1;
    logic        ram_ce_i = 1'b0, ram_we_i = 1'b0;
    logic [3:0]  ram_sel_i = '0;
    logic [31:0] ram_addr_i = '0, ram_data_i = '0;
    logic        ram_busy_o;
    logic [31:0] ram_data_o;
    logic        ram_data_rvalid_o;
    logic        data_mem_cyc_o, data_mem_stb_o, data_mem_we_o;
    logic [3:0]  data_mem_sel_o;
    logic [31:0] data_mem_addr_o, data_mem_data_o;
    logic [31:0] data_mem_data_i = '0;
    logic        data_mem_ack_i = 1'b0;
    logic        bus_err_o;

    sprint_ram_wb_bridge #(.REQ_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_core(clk_core), .rst_core(rst_core),
        .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
        .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i),
        .ram_busy_o(ram_busy_o), .ram_data_o(ram_data_o),
        .ram_data_rvalid_o(ram_data_rvalid_o),
        .data_mem_cyc_o(data_mem_cyc_o), .data_mem_stb_o(data_mem_stb_o),
        .data_mem_we_o(data_mem_we_o), .data_mem_sel_o(data_mem_sel_o),
        .data_mem_addr_o(data_mem_addr_o), .data_mem_data_o(data_mem_data_o),
        .data_mem_data_i(data_mem_data_i), .data_mem_ack_i(data_mem_ack_i),
        .bus_err_o(bus_err_o)
    );

    always #5 clk_core = ~clk_core;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (request-queue level) ----------------
    typedef struct {
        bit        we;
        bit [3:0]  sel;
        bit [31:0] addr;
        bit [31:0] data;
    } mreq_t;

    mreq_t     pend[$];
    mreq_t     m_cur, m_new;
    bit        m_cur_v, m_rv, m_err, m_acc, m_took, m_to;
    bit [31:0] m_rdata;
    int        m_el;

    // Pending queue holds accepted requests not yet on the bus; the one on the
    // bus is m_cur. A request arriving to a fully idle bridge goes straight out.
    always @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            pend.delete();
            m_cur_v = 0; m_rv = 0; m_err = 0; m_acc = 0; m_el = 0;
        end else begin
            m_new  = '{ram_we_i, ram_sel_i, ram_addr_i, ram_data_i};
            m_acc  = ram_ce_i && (pend.size() < DEPTH);
            m_took = 0; m_rv = 0; m_err = 0;
            if (!m_cur_v) begin
                if (pend.size() > 0) begin
                    m_cur = pend.pop_front(); m_cur_v = 1; m_el = 0;
                end else if (m_acc) begin
                    m_cur = m_new; m_cur_v = 1; m_el = 0; m_took = 1;
                end
            end else begin
                m_to = TMO_EN && !data_mem_ack_i && (m_el == TMO - 1);
                if (data_mem_ack_i || m_to) begin
                    if (!m_cur.we) begin
                        m_rv = 1;
                        m_rdata = data_mem_ack_i ? data_mem_data_i : 32'hDEADBEEF;
                    end
                    m_err = m_to;
                    if (data_mem_ack_i && pend.size() > 0) begin
                        m_cur = pend.pop_front(); m_el = 0;
                    end else m_cur_v = 0;
                end else m_el++;
            end
            if (m_acc && !m_took) pend.push_back(m_new);
        end
    end

    // Compare DUT against the model every cycle, just after the clock edge.
    always @(posedge clk_core) begin
        #1;
        if (!rst_core) begin
            chk("m_cyc", data_mem_cyc_o, m_cur_v);
            chk("m_stb", data_mem_stb_o, m_cur_v);
            chk("m_busy", ram_busy_o, pend.size() == DEPTH);
            chk("m_rvalid", ram_data_rvalid_o, m_rv);
            chk("m_err", bus_err_o, m_err);
            if (m_cur_v) begin
                chk("m_addr", data_mem_addr_o, {m_cur.addr[31:2], 2'b00});
                chk("m_we", data_mem_we_o, m_cur.we);
                chk("m_sel", data_mem_sel_o, m_cur.sel);
                chk("m_wdata", data_mem_data_o, m_cur.data);
            end
            if (m_rv) chk("m_rdata", ram_data_o, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_in();
        ram_ce_i = 0;
        data_mem_ack_i = 0;
        data_mem_data_i = $urandom;
    endtask

    task automatic put_req(input bit we, input bit [3:0] sel, input bit [31:0] a, input bit [31:0] d);
        ram_ce_i = 1; ram_we_i = we; ram_sel_i = sel; ram_addr_i = a; ram_data_i = d;
    endtask

    logic [31:0] issq[$], rvq[$];
    int cyc_cnt;

    initial begin
        // Reset values
        @(negedge clk_core);
        chk("rst_cyc", data_mem_cyc_o, 0);
        chk("rst_stb", data_mem_stb_o, 0);
        chk("rst_we", data_mem_we_o, 0);
        chk("rst_sel", data_mem_sel_o, 0);
        chk("rst_addr", data_mem_addr_o, 0);
        chk("rst_wdata", data_mem_data_o, 0);
        chk("rst_rdata", ram_data_o, 0);
        chk("rst_rvalid", ram_data_rvalid_o, 0);
        chk("rst_busy", ram_busy_o, 0);
        chk("rst_err", bus_err_o, 0);
        @(negedge clk_core); rst_core = 0;

        // Ack while idle is ignored
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_core);
            data_mem_ack_i = 1; data_mem_data_i = 32'h0BAD0BAD;
            @(negedge clk_core);
            chk("idle_ack_cyc", data_mem_cyc_o, 0);
            chk("idle_ack_rvalid", ram_data_rvalid_o, 0);
            chk("idle_ack_busy", ram_busy_o, 0);
            idle_in();
        end

        // Single read to 0x1006, ack on the third bus cycle
        @(negedge clk_core); put_req(0, 4'b1111, 32'h0000_1006, 32'h0);
        cyc_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_core); idle_in();
            if (c == 1) begin
                chk("t1_addr", data_mem_addr_o, 32'h0000_1004);
                chk("t1_sel", data_mem_sel_o, 4'b1111);
                chk("t1_we", data_mem_we_o, 0);
            end
            if (data_mem_cyc_o) cyc_cnt++;
            if (c == 3) begin data_mem_ack_i = 1; data_mem_data_i = 32'h1234_5678; end
            if (c == 4) begin
                chk("t1_rvalid", ram_data_rvalid_o, 1);
                chk("t1_rdata", ram_data_o, 32'h1234_5678);
            end
        end
        chk("t1_cyc_len", cyc_cnt, 3);
        @(negedge clk_core);
        chk("t1_rvalid_pulse", ram_data_rvalid_o, 0);

        // Single write, ack on the first bus cycle
        put_req(1, 4'b0011, 32'h20, 32'hCAFE_F00D);
        @(negedge clk_core); idle_in();
        chk("t2_cyc", data_mem_cyc_o, 1);
        chk("t2_we", data_mem_we_o, 1);
        chk("t2_sel", data_mem_sel_o, 4'b0011);
        chk("t2_addr", data_mem_addr_o, 32'h20);
        chk("t2_wdata", data_mem_data_o, 32'hCAFE_F00D);
        data_mem_ack_i = 1;
        @(negedge clk_core); idle_in();
        chk("t2_cyc_drop", data_mem_cyc_o, 0);
        chk("t2_no_rvalid", ram_data_rvalid_o, 0);

        // Three back-to-back requests, each acked on its fifth bus cycle
        issq.delete(); rvq.delete();
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk_core);
            if (c >= 1 && c <= 15) chk("t3_cyc_cont", data_mem_cyc_o, 1);
            if (c == 16) chk("t3_cyc_end", data_mem_cyc_o, 0);
            if (c >= 3 && c <= 5) chk("t3_busy", ram_busy_o, 1);
            if (c == 6) chk("t3_busy_rel", ram_busy_o, 0);
            if (ram_data_rvalid_o) rvq.push_back(ram_data_o);
            idle_in();
            if (c == 0) put_req(0, 4'hF, 32'h10, 32'h0);
            if (c == 1) put_req(1, 4'hF, 32'h14, 32'h1111_2222);
            if (c == 2) put_req(0, 4'hF, 32'h18, 32'h0);
            if (c == 5 || c == 10 || c == 15) begin
                data_mem_ack_i = 1;
                data_mem_data_i = 32'hA000_0000 + c;
                issq.push_back(data_mem_addr_o);
            end
        end
        chk("t3_n_issued", issq.size(), 3);
        if (issq.size() == 3) begin
            chk("t3_issue0", issq[0], 32'h10);
            chk("t3_issue1", issq[1], 32'h14);
            chk("t3_issue2", issq[2], 32'h18);
        end
        chk("t3_n_rvalid", rvq.size(), 2);
        if (rvq.size() == 2) begin
            chk("t3_rv0", rvq[0], 32'hA000_0005);
            chk("t3_rv1", rvq[1], 32'hA000_000F);
        end

        // Reset mid-read, then a late ack
        @(negedge clk_core); put_req(0, 4'hF, 32'h40, 32'h0);
        @(negedge clk_core); idle_in();
        @(negedge clk_core);
        chk("t4_cyc_before", data_mem_cyc_o, 1);
        rst_core = 1; #1;
        chk("t4_cyc_rst", data_mem_cyc_o, 0);
        chk("t4_stb_rst", data_mem_stb_o, 0);
        chk("t4_rvalid_rst", ram_data_rvalid_o, 0);
        chk("t4_busy_rst", ram_busy_o, 0);
        @(negedge clk_core); rst_core = 0;
        @(negedge clk_core); data_mem_ack_i = 1; data_mem_data_i = 32'h7777_7777;
        @(negedge clk_core); idle_in();
        chk("t4_late_rvalid", ram_data_rvalid_o, 0);
        chk("t4_late_cyc", data_mem_cyc_o, 0);
        chk("t4_late_busy", ram_busy_o, 0);

`ifdef WB_TIMEOUT_EN
        // Read never acked: abort after TMO bus cycles, then the queued write issues
        @(negedge clk_core); put_req(0, 4'hF, 32'h80, 32'h0);
        @(negedge clk_core); idle_in(); put_req(1, 4'h5, 32'h84, 32'h55AA_55AA);
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk_core); idle_in();
            chk("t5_cyc_wait", data_mem_cyc_o, 1);
            chk("t5_addr_wait", data_mem_addr_o, 32'h80);
            chk("t5_err_wait", bus_err_o, 0);
        end
        @(negedge clk_core); idle_in();
        chk("t5_err", bus_err_o, 1);
        chk("t5_rvalid", ram_data_rvalid_o, 1);
        chk("t5_rdata", ram_data_o, 32'hDEADBEEF);
        chk("t5_cyc_drop", data_mem_cyc_o, 0);
        @(negedge clk_core); idle_in();
        chk("t5_next_cyc", data_mem_cyc_o, 1);
        chk("t5_next_addr", data_mem_addr_o, 32'h84);
        chk("t5_next_we", data_mem_we_o, 1);
        chk("t5_err_pulse", bus_err_o, 0);
        data_mem_ack_i = 1;
        @(negedge clk_core); idle_in();
        chk("t5_done_cyc", data_mem_cyc_o, 0);
        chk("t5_done_rvalid", ram_data_rvalid_o, 0);
`endif

        // Randomized traffic; a rejected request is held until accepted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_core);
            if (c == 2000) rst_core = 1;
            if (c == 2001) rst_core = 0;
            if (!(ram_ce_i && !m_acc)) begin
                ram_ce_i   = ($urandom_range(0, 2) != 0);
                ram_we_i   = $urandom_range(0, 1);
                ram_sel_i  = $urandom;
                ram_addr_i = $urandom;
                ram_data_i = $urandom;
            end
            if (m_cur_v)
                data_mem_ack_i = (c < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
            else
                data_mem_ack_i = ($urandom_range(0, 7) == 0);
            data_mem_data_i = $urandom;
        end
        @(negedge clk_core); idle_in();
        repeat (30) @(negedge clk_core);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
